// File: rtl/escalonador_andares.sv
// Elevator floor scheduler: debounces the floor sensor, latches call
// requests, serves them in SCAN order and faults on a stalled motor.
//
// state  | meaning
// -------+-----------------------------------------------------------
// PARADO | idle, waiting for a latched request
// DECIDE | one-cycle direction choice (keep dir, else reverse, else idle)
// SOBE   | motor up, watching for debounced floor changes
// DESCE  | motor down, watching for debounced floor changes
// PORTA  | door open for T_PORTA cycles at the served floor
// FALHA  | motion watchdog expired; held until reset
module escalonador_andares #(
    parameter int ESTAVEL = 3,
    parameter int T_PORTA = 50,
    parameter int T_MAX   = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] andar_sensor,
    input  logic       sensor_valido,
    input  logic [3:0] pedido,
    output logic       motor_sobe,
    output logic       motor_desce,
    output logic       porta_aberta,
    output logic [1:0] andar_atual,
    output logic [3:0] pendentes,
    output logic       falha,
    output logic [2:0] estado_db
);

    localparam int CW = $clog2(ESTAVEL + 1);
    localparam int TW = $clog2(T_PORTA + 1);
    localparam int WW = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        PARADO = 3'd0,
        DECIDE = 3'd1,
        SOBE   = 3'd2,
        DESCE  = 3'd3,
        PORTA  = 3'd4,
        FALHA  = 3'd5
    } estado_t;

    estado_t       state_q, state_d;
    logic          dir_q, dir_d;          // 0 = up, 1 = down
    logic [1:0]    andar_q, andar_d;
    logic [1:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] run_len;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [3:0]    pend_q, pend_d;
    logic          motor_sobe_q, motor_sobe_d;
    logic          motor_desce_q, motor_desce_d;
    logic          porta_q, porta_d;
    logic          falha_q, falha_d;

    logic          chg;                   // debounced floor change accepted this cycle
    logic [3:0]    sel_atual;             // one-hot of current floor
    logic [3:0]    sel_novo;              // one-hot of floor being accepted
    logic [3:0]    acima, abaixo;
    logic          req_acima, req_abaixo;
    logic [3:0]    clr_mask, absorb_mask;

    // Debounce: count consecutive valid strobes of one value that differs from the current floor
    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        andar_d = andar_q;
        chg     = 1'b0;
        run_len = CW'(1);
        if (sensor_valido) begin
            cand_d = andar_sensor;
            if (andar_sensor == andar_q) begin
                cnt_d = '0;
            end else begin
                run_len = (andar_sensor == cand_q && cnt_q != '0) ? cnt_q + CW'(1) : CW'(1);
                if (run_len >= CW'(ESTAVEL)) begin
                    chg     = 1'b1;
                    andar_d = andar_sensor;
                    cnt_d   = '0;
                end else begin
                    cnt_d = run_len;
                end
            end
        end
    end

    // Request masks relative to the current floor
    always_comb begin
        sel_atual  = 4'b0001 << andar_q;
        sel_novo   = 4'b0001 << andar_sensor;
        acima      = ~((sel_atual << 1) - 4'd1);
        abaixo     = sel_atual - 4'd1;
        req_acima  = |(pend_q & acima);
        req_abaixo = |(pend_q & abaixo);
    end

    // Next-state, timers, request clear/absorb and registered output values
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        tmr_d       = tmr_q;
        wd_d        = wd_q;
        clr_mask    = 4'b0000;
        absorb_mask = 4'b0000;
        case (state_q)
            PARADO: begin
                if (|(pend_q & sel_atual)) begin
                    state_d  = PORTA;
                    clr_mask = sel_atual;
                    tmr_d    = TW'(T_PORTA - 1);
                end else if (|pend_q) begin
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                wd_d = '0;
                if (!dir_q) begin
                    if (req_acima) begin
                        state_d = SOBE;
                    end else if (req_abaixo) begin
                        dir_d   = 1'b1;
                        state_d = DESCE;
                    end else begin
                        state_d = PARADO;
                    end
                end else begin
                    if (req_abaixo) begin
                        state_d = DESCE;
                    end else if (req_acima) begin
                        dir_d   = 1'b0;
                        state_d = SOBE;
                    end else begin
                        state_d = PARADO;
                    end
                end
            end
            SOBE, DESCE: begin
                if (chg) begin
                    wd_d = '0;
                    if (|(pend_q & sel_novo)) begin
                        state_d  = PORTA;
                        clr_mask = sel_novo;
                        tmr_d    = TW'(T_PORTA - 1);
                    end else if ((state_q == SOBE && andar_sensor == 2'd3) ||
                                 (state_q == DESCE && andar_sensor == 2'd0)) begin
                        state_d = DECIDE;
                    end
                end else if (wd_q == WW'(T_MAX - 1)) begin
                    state_d = FALHA;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            PORTA: begin
                absorb_mask = sel_atual;
                if (|(pedido & sel_atual)) begin
                    tmr_d = TW'(T_PORTA - 1);
                end else if (tmr_q == '0) begin
                    state_d = DECIDE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            FALHA: begin
                state_d = FALHA;
            end
            default: begin
                state_d = PARADO;
            end
        endcase

        pend_d        = (pend_q & ~clr_mask) | (pedido & ~absorb_mask);
        motor_sobe_d  = (state_d == SOBE);
        motor_desce_d = (state_d == DESCE);
        porta_d       = (state_d == PORTA);
        falha_d       = (state_d == FALHA);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= PARADO;
            dir_q         <= 1'b0;
            andar_q       <= 2'd0;
            cand_q        <= 2'd0;
            cnt_q         <= '0;
            tmr_q         <= '0;
            wd_q          <= '0;
            pend_q        <= 4'b0000;
            motor_sobe_q  <= 1'b0;
            motor_desce_q <= 1'b0;
            porta_q       <= 1'b0;
            falha_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            andar_q       <= andar_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            tmr_q         <= tmr_d;
            wd_q          <= wd_d;
            pend_q        <= pend_d;
            motor_sobe_q  <= motor_sobe_d;
            motor_desce_q <= motor_desce_d;
            porta_q       <= porta_d;
            falha_q       <= falha_d;
        end
    end

    assign motor_sobe   = motor_sobe_q;
    assign motor_desce  = motor_desce_q;
    assign porta_aberta = porta_q;
    assign andar_atual  = andar_q;
    assign pendentes    = pend_q;
    assign falha        = falha_q;
    assign estado_db    = state_q;

endmodule

// File: tb/tb_escalonador_andares.sv
// Bench for escalonador_andares: directed scenarios plus randomized SCAN
// and debounce runs checked against a simple reference model.
module tb_escalonador_andares;

    localparam int ESTAVEL = 3;
    localparam int T_PORTA = 50;
    localparam int T_MAX   = 1000;

    logic       clock;
    logic       reset;
    logic [1:0] andar_sensor;
    logic       sensor_valido;
    logic [3:0] pedido;
    logic       motor_sobe;
    logic       motor_desce;
    logic       porta_aberta;
    logic [1:0] andar_atual;
    logic [3:0] pendentes;
    logic       falha;
    logic [2:0] estado_db;

    int n_cmp = 0;
    int n_err = 0;
    int served[$];

    escalonador_andares #(.ESTAVEL(ESTAVEL), .T_PORTA(T_PORTA), .T_MAX(T_MAX)) dut (
        .clock        (clock),
        .reset        (reset),
        .andar_sensor (andar_sensor),
        .sensor_valido(sensor_valido),
        .pedido       (pedido),
        .motor_sobe   (motor_sobe),
        .motor_desce  (motor_desce),
        .porta_aberta (porta_aberta),
        .andar_atual  (andar_atual),
        .pendentes    (pendentes),
        .falha        (falha),
        .estado_db    (estado_db)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        pedido        = 4'b0000;
        sensor_valido = 1'b0;
        andar_sensor  = 2'd0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic strobe(input logic [1:0] v);
        andar_sensor  = v;
        sensor_valido = 1'b1;
        step();
        sensor_valido = 1'b0;
    endtask

    task automatic wait_sobe(input string nm);
        int n = 0;
        while (!motor_sobe && n < 20) begin n++; step(); end
        n_cmp++;
        if (!motor_sobe) begin n_err++; $display("FAIL %s_wait_sobe: motor_sobe=%0b required 1 within 20 cycles", nm, motor_sobe); end
    endtask

    // Runs the car with a plant that answers the motor with sensor strobes until idle
    task automatic run_until_idle(input string nm);
        int ph = 0;
        int cyc = 0;
        logic prev_door = 1'b0;
        logic [1:0] tgt = 2'd0;
        served.delete();
        while (cyc < 3000 && !(estado_db == 3'd0 && pendentes == 4'b0000 && served.size() > 0)) begin
            if (porta_aberta && !prev_door) served.push_back(int'(andar_atual));
            prev_door = porta_aberta;
            if (motor_sobe || motor_desce) begin
                ph++;
                if (ph == 3) tgt = motor_sobe ? andar_atual + 2'd1 : andar_atual - 2'd1;
                if (ph >= 3 && ph < 3 + ESTAVEL) begin
                    sensor_valido = 1'b1;
                    andar_sensor  = tgt;
                end else begin
                    sensor_valido = 1'b0;
                end
                if (ph >= 3 + ESTAVEL + 1) ph = 0;
            end else begin
                ph = 0;
                sensor_valido = 1'b0;
            end
            step();
            cyc++;
        end
        sensor_valido = 1'b0;
        n_cmp++;
        if (cyc >= 3000) begin n_err++; $display("FAIL %s_timeout: estado=%0d pendentes=%b required idle within 3000 cycles", nm, estado_db, pendentes); end
    endtask

    task automatic test_reset();
        reset = 1'b0; pedido = 4'b0000; sensor_valido = 1'b0; andar_sensor = 2'd0;
        step();
        n_cmp++;
        if ({motor_sobe, motor_desce, porta_aberta, falha, andar_atual, pendentes, estado_db} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_state: sobe=%0b desce=%0b porta=%0b falha=%0b andar=%0d pend=%b estado=%0d required all 0",
                     motor_sobe, motor_desce, porta_aberta, falha, andar_atual, pendentes, estado_db);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int n;
        do_reset();
        pedido = 4'b0100; step(); pedido = 4'b0000;
        n_cmp++; if (pendentes !== 4'b0100) begin n_err++; $display("FAIL basic_latch: pend=%b required 0100", pendentes); end
        wait_sobe("basic");
        n_cmp++; if (estado_db !== 3'd2) begin n_err++; $display("FAIL basic_sobe_state: estado=%0d required 2", estado_db); end
        repeat (ESTAVEL) strobe(2'd1);
        n_cmp++; if (andar_atual !== 2'd1 || estado_db !== 3'd2) begin n_err++; $display("FAIL basic_floor1: andar=%0d estado=%0d required 1/2", andar_atual, estado_db); end
        repeat (ESTAVEL) strobe(2'd2);
        n_cmp++;
        if (estado_db !== 3'd4 || andar_atual !== 2'd2 || pendentes !== 4'b0000 || porta_aberta !== 1'b1 || motor_sobe !== 1'b0) begin
            n_err++;
            $display("FAIL basic_porta: estado=%0d andar=%0d pend=%b porta=%0b sobe=%0b required 4/2/0000/1/0",
                     estado_db, andar_atual, pendentes, porta_aberta, motor_sobe);
        end
        n = 0;
        while (porta_aberta && n < 200) begin n++; step(); end
        n_cmp++; if (n != T_PORTA) begin n_err++; $display("FAIL basic_door_len: %0d cycles required %0d", n, T_PORTA); end
        n_cmp++; if (estado_db !== 3'd1) begin n_err++; $display("FAIL basic_after_door: estado=%0d required 1", estado_db); end
        step();
        n_cmp++; if (estado_db !== 3'd0) begin n_err++; $display("FAIL basic_parado: estado=%0d required 0", estado_db); end
    endtask

    // SCAN reference: car idle at s heading up; serve s, then upward ascending, then downward descending
    task automatic test_scan(input int s, input logic [3:0] set);
        int exp_q[$];
        logic [3:0] first_req;
        do_reset();
        first_req = 4'b0001 << s;
        pedido = first_req; step(); pedido = 4'b0000;
        run_until_idle("scan_goto");
        n_cmp++;
        if (served.size() != 1 || served[0] != s) begin n_err++; $display("FAIL scan_goto: served=%p required [%0d]", served, s); end
        if (set[s]) exp_q.push_back(s);
        for (int f = s + 1; f < 4; f++) if (set[f]) exp_q.push_back(f);
        for (int f = s - 1; f >= 0; f--) if (set[f]) exp_q.push_back(f);
        pedido = set; step(); pedido = 4'b0000;
        run_until_idle("scan_run");
        n_cmp++;
        if (served != exp_q) begin n_err++; $display("FAIL scan_order: start=%0d set=%b served=%p required %p", s, set, served, exp_q); end
    endtask

    task automatic test_debounce();
        logic [1:0] dirs[6];
        logic [1:0] hist[$];
        logic [1:0] cur = 2'd0;
        logic [1:0] v = 2'd1;
        int ok = 1;
        do_reset();
        repeat (ESTAVEL) strobe(2'd1);
        cur = 2'd1;
        n_cmp++; if (andar_atual !== 2'd1 || estado_db !== 3'd0) begin n_err++; $display("FAIL deb_setup: andar=%0d estado=%0d required 1/0", andar_atual, estado_db); end
        dirs[0] = 2'd2; dirs[1] = 2'd2; dirs[2] = 2'd1; dirs[3] = 2'd2; dirs[4] = 2'd2; dirs[5] = 2'd2;
        for (int i = 0; i < 6; i++) begin
            strobe(dirs[i]);
            n_cmp++;
            if (andar_atual !== ((i == 5) ? 2'd2 : 2'd1)) begin
                n_err++; $display("FAIL deb_noisy_%0d: andar=%0d required %0d", i, andar_atual, (i == 5) ? 2 : 1);
            end
        end
        cur = 2'd2;
        hist.delete();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) v = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                andar_sensor = 2'($urandom_range(0, 3));
                sensor_valido = 1'b0;
                step();
            end
            strobe(v);
            hist.push_back(v);
            if (hist.size() >= ESTAVEL && hist[$] == hist[$-1] && hist[$] == hist[$-2] && hist[$] != cur) cur = hist[$];
            if (andar_atual !== cur || estado_db !== 3'd0) ok = 0;
            n_cmp++;
            if (andar_atual !== cur || estado_db !== 3'd0) begin
                n_err++; $display("FAIL deb_random_%0d: andar=%0d estado=%0d required %0d/0", i, andar_atual, estado_db, cur);
            end
        end
    endtask

    task automatic test_watchdog();
        int n = 0;
        do_reset();
        pedido = 4'b1000; step(); pedido = 4'b0000;
        wait_sobe("wd");
        while (motor_sobe && n < 2000) begin n++; step(); end
        n_cmp++; if (n != T_MAX) begin n_err++; $display("FAIL wd_motor_cycles: %0d required %0d", n, T_MAX); end
        n_cmp++;
        if (falha !== 1'b1 || estado_db !== 3'd5 || motor_sobe !== 1'b0 || motor_desce !== 1'b0 || porta_aberta !== 1'b0) begin
            n_err++; $display("FAIL wd_falha: falha=%0b estado=%0d sobe=%0b desce=%0b porta=%0b required 1/5/0/0/0",
                              falha, estado_db, motor_sobe, motor_desce, porta_aberta);
        end
        pedido = 4'b0001; step(); pedido = 4'b0000;
        repeat (5) step();
        n_cmp++; if (pendentes !== 4'b1001 || estado_db !== 3'd5) begin n_err++; $display("FAIL wd_latch_in_falha: pend=%b estado=%0d required 1001/5", pendentes, estado_db); end
        reset = 1'b0; step(); reset = 1'b1;
        n_cmp++; if (estado_db !== 3'd0 || falha !== 1'b0 || pendentes !== 4'b0000) begin n_err++; $display("FAIL wd_reset: estado=%0d falha=%0b pend=%b required 0/0/0000", estado_db, falha, pendentes); end
    endtask

    task automatic test_porta_restart();
        int n = 0;
        int k;
        do_reset();
        k = $urandom_range(5, 40);
        pedido = 4'b0001; step(); pedido = 4'b0000;
        while (!porta_aberta && n < 20) begin n++; step(); end
        n = 0;
        while (porta_aberta && n < 300) begin
            n++;
            pedido = (n == k) ? 4'b0001 : 4'b0000;
            step();
            if (n == k) begin
                n_cmp++; if (pendentes !== 4'b0000) begin n_err++; $display("FAIL porta_absorb: pend=%b required 0000", pendentes); end
            end
        end
        pedido = 4'b0000;
        n_cmp++; if (n != k + T_PORTA) begin n_err++; $display("FAIL porta_restart_len: %0d cycles required %0d", n, k + T_PORTA); end
        step();
        n_cmp++; if (estado_db !== 3'd0 || pendentes !== 4'b0000 || porta_aberta !== 1'b0) begin n_err++; $display("FAIL porta_no_reopen: estado=%0d pend=%b porta=%0b required 0/0000/0", estado_db, pendentes, porta_aberta); end
    endtask

    task automatic test_reset_sobe();
        do_reset();
        pedido = 4'b1100; step(); pedido = 4'b0000;
        wait_sobe("rst_sobe");
        repeat (ESTAVEL) strobe(2'd1);
        step();
        reset = 1'b0; step(); reset = 1'b1;
        n_cmp++;
        if ({motor_sobe, motor_desce, porta_aberta, falha, andar_atual, pendentes, estado_db} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_in_sobe: sobe=%0b desce=%0b porta=%0b falha=%0b andar=%0d pend=%b estado=%0d required all 0",
                     motor_sobe, motor_desce, porta_aberta, falha, andar_atual, pendentes, estado_db);
        end
    endtask

    initial begin
        reset = 1'b0; pedido = 4'b0000; sensor_valido = 1'b0; andar_sensor = 2'd0;
        test_reset();
        test_basic();
        test_scan(1, 4'b1001);
        for (int i = 0; i < 16; i++) test_scan(int'($urandom_range(0, 3)), 4'($urandom_range(1, 15)));
        test_debounce();
        test_watchdog();
        test_porta_restart();
        test_reset_sobe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
